// File: rtl/ilb_seq_pkg.sv
// Shared definitions for the ILB frame sequencer: state encoding and default geometry.
package ilb_seq_pkg;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int K_DEF     = 7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PIX  = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_RECV = 3'd3,
        S_SHIFT     = 3'd4,
        S_CONV      = 3'd5,
        S_ADVANCE   = 3'd6,
        S_DONE      = 3'd7
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ilb_pos_counter.sv
// Row/column position of the pixel in flight; columns wrap into the next row, last flags the final pixel.
module ilb_pos_counter
    import ilb_seq_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CW    = $clog2(max_int(IMG_W, IMG_H))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);

    assign last = (row == ROW_MAX) && (col == COL_MAX);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ilb_frame_sequencer.sv
// Per-pixel ILB send/read, window shift and convolution launch for one frame.
// Optional handshake watchdog compiled in with ILB_SEQ_WATCHDOG_EN.
module ilb_frame_sequencer
    import ilb_seq_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int CW    = $clog2(max_int(IMG_W, IMG_H))
`ifdef ILB_SEQ_WATCHDOG_EN
    ,
    parameter int TO_CYCLES = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          uart_valid,
    output logic          ilb_send_enable,
    input  logic          byte_sent,
    output logic          ilb_read_enable,
    input  logic          bytes_recieved,
    output logic          win_shift,
    output logic          conv_start,
    input  logic          conv_done,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
`ifdef ILB_SEQ_WATCHDOG_EN
    ,
    output logic          timeout_err
`endif
);

    localparam logic [CW-1:0] KM1 = CW'(K - 1);

    seq_state_t state;
    logic       pend;
    logic       pend_clr;
    logic       pos_clr;
    logic       pos_adv;
    logic       last;
    logic       win_ok;

    assign pend_clr = (state == S_WAIT_PIX) && pend;
    assign pos_clr  = ((state == S_IDLE) && start) || (state == S_DONE);
    assign pos_adv  = (state == S_ADVANCE) && !bytes_recieved;
    assign win_ok   = (row >= KM1) && (col >= KM1);

    ilb_pos_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .CW   (CW)
    ) u_pos (
        .clk (clk),
        .rst (rst),
        .clr (pos_clr),
        .adv (pos_adv),
        .row (row),
        .col (col),
        .last(last)
    );

`ifdef ILB_SEQ_WATCHDOG_EN
    localparam int WD_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;
    logic            wd_leave;
    logic            wd_expire;

    assign wd_active = (state == S_SEND) || (state == S_WAIT_RECV) || (state == S_CONV);
    // Leaving a watched state restarts the count, including SEND -> WAIT_RECV.
    assign wd_leave  = ((state == S_SEND) && byte_sent) ||
                       ((state == S_WAIT_RECV) && bytes_recieved) ||
                       ((state == S_CONV) && conv_done);
    assign wd_expire = wd_active && (wd_cnt == WD_W'(TO_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            pend            <= 1'b0;
            ilb_send_enable <= 1'b0;
            ilb_read_enable <= 1'b0;
            win_shift       <= 1'b0;
            conv_start      <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            overrun         <= 1'b0;
`ifdef ILB_SEQ_WATCHDOG_EN
            timeout_err     <= 1'b0;
            wd_cnt          <= '0;
`endif
        end else begin
            win_shift  <= 1'b0;
            conv_start <= 1'b0;
            frame_done <= 1'b0;

            // A pixel landing in the hand-off cycle re-arms pend instead of overrunning.
            if (state == S_IDLE) begin
                pend <= 1'b0;
            end else if (uart_valid) begin
                if (pend && !pend_clr)
                    overrun <= 1'b1;
                else
                    pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        overrun <= 1'b0;
`ifdef ILB_SEQ_WATCHDOG_EN
                        timeout_err <= 1'b0;
`endif
                        busy    <= 1'b1;
                        state   <= S_WAIT_PIX;
                    end
                end
                S_WAIT_PIX: begin
                    if (pend) begin
                        ilb_send_enable <= 1'b1;
                        state           <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (byte_sent) begin
                        ilb_send_enable <= 1'b0;
                        ilb_read_enable <= 1'b1;
                        state           <= S_WAIT_RECV;
                    end
                end
                S_WAIT_RECV: begin
                    if (bytes_recieved) begin
                        ilb_read_enable <= 1'b0;
                        win_shift       <= 1'b1;
                        state           <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (win_ok) begin
                        conv_start <= 1'b1;
                        state      <= S_CONV;
                    end else begin
                        state <= S_ADVANCE;
                    end
                end
                S_CONV: begin
                    if (conv_done)
                        state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    // Hold until the ILB interface has dropped bytes_recieved and is idle again.
                    if (!bytes_recieved) begin
                        if (last) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            state <= S_WAIT_PIX;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

`ifdef ILB_SEQ_WATCHDOG_EN
            wd_cnt <= (wd_active && !wd_leave) ? wd_cnt + 1'b1 : '0;
            if (wd_expire) begin
                timeout_err     <= 1'b1;
                ilb_send_enable <= 1'b0;
                ilb_read_enable <= 1'b0;
                win_shift       <= 1'b0;
                conv_start      <= 1'b0;
                frame_done      <= 1'b1;
                busy            <= 1'b0;
                wd_cnt          <= '0;
                state           <= S_IDLE;
            end
`endif
        end
    end

endmodule
